mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 21 ++
 rtl/mem_stage_ctrl_if.sv | 21 ++
 rtl/mem_stage_ctrl_wait_ctr.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared processor definitions: memory opcodes and the MEM-stage FSM encoding.
package mem_stage_ctrl_pkg;

    localparam logic [3:0] LW_OP_DEF = 4'b1000;
    localparam logic [3:0] SW_OP_DEF = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // True when the EX/MEM slot holds a real load or store.
    function automatic logic is_mem_op(input logic       valid,
                                       input logic [3:0] op,
                                       input logic [3:0] lw_op,
                                       input logic [3:0] sw_op);
        return valid && ((op == lw_op) || (op == sw_op));
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_stage_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_stage_ctrl_wait_ctr.sv
// Wait counter for the BUSY phase; tc flags the last permitted wait cycle.
module mem_wait_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt;

    // Count BUSY cycles; cleared whenever the FSM is outside BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the pipe while a load/store waits on the data memory.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access in flight; pass-through or capture a new load/store
// ST_BUSY | request on the bus, waiting for mem_ack or the timeout
// ST_DONE | one-cycle completion: pipe released, load result presented
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter logic [3:0] LW_OP   = LW_OP_DEF,
    parameter logic [3:0] SW_OP   = SW_OP_DEF,
    parameter int         TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [15:0]       mem_addr_i,
    input  logic [15:0]       alu_data_i,
    input  logic [3:0]        rd_i,
    mem_stage_ctrl_if.master  mem,
    output logic              pipe_wen,
    output logic [15:0]       load_data_o,
    output logic [3:0]        load_rd_o,
    output logic              load_valid_o,
    output logic              err_o
);

    mem_state_e  state;
    mem_state_e  state_nxt;
    logic        mem_op;
    logic        capture;
    logic        req;
    logic        wen_fsm;
    logic        ack_hit;
    logic        tmo_hit;
    logic        tc;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [3:0]  rd_q;

    assign mem_op = is_mem_op(valid_i, op_i, LW_OP, SW_OP);

    mem_wait_ctr #(.TIMEOUT(TIMEOUT)) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .clr (state != ST_BUSY),
        .en  (state == ST_BUSY),
        .tc  (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode; ack has priority over the timeout.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        req       = 1'b0;
        wen_fsm   = 1'b1;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    wen_fsm   = 1'b0;
                    capture   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                wen_fsm = 1'b0;
                req     = 1'b1;
                if (mem.mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tc) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the access so the bus stays stable for the whole BUSY phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else if (capture) begin
            we_q    <= (op_i == SW_OP);
            addr_q  <= mem_addr_i;
            wdata_q <= alu_data_i;
            rd_q    <= rd_i;
        end
    end

    // Load result (zeroed on timeout) and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data_o <= '0;
            load_rd_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            if (ack_hit && !we_q) begin
                load_data_o <= mem.mem_rdata;
                load_rd_o   <= rd_q;
            end else if (tmo_hit && !we_q) begin
                load_data_o <= '0;
                load_rd_o   <= rd_q;
            end
            if (tmo_hit) begin
                err_o <= 1'b1;
            end
        end
    end

    // Upstream registers must be free to load while reset is held.
    assign pipe_wen      = !rst || wen_fsm;
    assign load_valid_o  = (state == ST_DONE) && !we_q;
    assign mem.mem_req   = req;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, corner sequences, random traffic.
module tb_mem_stage_ctrl;

    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] SW  = 4'b1001;
    localparam logic [3:0] ADD = 4'b0000;
    localparam int         TMO = 16;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  rd;
        int          ack_at;
        logic [15:0] rdata;
        int          exp_low;
        int          exp_req;
        int          exp_lv;
        logic [15:0] exp_data;
        logic [3:0]  exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [3:0]  op_i;
    logic [15:0] mem_addr_i;
    logic [15:0] alu_data_i;
    logic [3:0]  rd_i;
    logic        pipe_wen;
    logic [15:0] load_data_o;
    logic [3:0]  load_rd_o;
    logic        load_valid_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_ctrl_if mem_bus ();

    mem_stage_ctrl #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .op_i         (op_i),
        .mem_addr_i   (mem_addr_i),
        .alu_data_i   (alu_data_i),
        .rd_i         (rd_i),
        .mem          (mem_bus),
        .pipe_wen     (pipe_wen),
        .load_data_o  (load_data_o),
        .load_rd_o    (load_rd_o),
        .load_valid_o (load_valid_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] out_bus();
        return {8'h0, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                load_data_o, load_rd_o, load_valid_o, err_o};
    endfunction

    // Presents one instruction, plays the memory side, and records what the bus did.
    task automatic run_txn(input vec_t t, output int low, output int req, output int lv,
                           output bit stable, output logic [15:0] lvd, output bit hung);
        bit released;
        low = 0; req = 0; lv = 0; stable = 1'b1; lvd = '0; released = 1'b0;
        @(posedge clk); #1;
        valid_i = t.v; op_i = t.op; mem_addr_i = t.addr; alu_data_i = t.wdata; rd_i = t.rd;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!pipe_wen) low++;
            if (load_valid_o) begin
                lv++;
                lvd = load_data_o;
            end
            if (mem_bus.mem_req) begin
                req++;
                if (mem_bus.mem_addr !== t.addr || mem_bus.mem_wdata !== t.wdata ||
                    mem_bus.mem_we !== (t.op == SW))
                    stable = 1'b0;
                if (req == t.ack_at) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = t.rdata;
                end
            end
            if (released) break;
            if (pipe_wen) released = 1'b1;
            @(posedge clk); #1;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = 16'($urandom);
            if (released) begin
                valid_i = 1'b0;
                op_i    = 4'($urandom);
            end
        end
        hung = !released;
        valid_i = 1'b0;
    endtask

    vec_t        vecs[7];
    vec_t        t;
    int          low, req, lv, sel, busy;
    bit          stable, hung, seen, is_mem, is_ld, acked;
    logic [15:0] lvd, m_data;
    logic [3:0]  m_rd;
    logic        m_err;

    initial begin
        //            v     op   addr      wdata     rd    ack rdata     low req lv data      rd    err
        vecs[0] = '{1'b1, ADD, 16'h0000, 16'h0000, 4'd2,  1, 16'h0000,  0,  0, 0, 16'h0000, 4'd0, 1'b0};
        vecs[1] = '{1'b1, LW,  16'h0040, 16'h0000, 4'd5,  1, 16'hBEEF,  2,  1, 1, 16'hBEEF, 4'd5, 1'b0};
        vecs[2] = '{1'b1, SW,  16'h0010, 16'h1234, 4'd1,  4, 16'h5555,  5,  4, 0, 16'hBEEF, 4'd5, 1'b0};
        vecs[3] = '{1'b0, LW,  16'h0080, 16'h0000, 4'd6,  1, 16'h7777,  0,  0, 0, 16'hBEEF, 4'd5, 1'b0};
        vecs[4] = '{1'b1, LW,  16'h0100, 16'h0000, 4'd9, 16, 16'hCAFE, 17, 16, 1, 16'hCAFE, 4'd9, 1'b0};
        vecs[5] = '{1'b1, LW,  16'h0044, 16'h0000, 4'd3,  0, 16'h1111, 17, 16, 1, 16'h0000, 4'd3, 1'b1};
        vecs[6] = '{1'b1, SW,  16'h0020, 16'hABCD, 4'd4,  2, 16'h2222,  3,  2, 0, 16'h0000, 4'd3, 1'b1};

        // Reset state with a load sitting on the inputs.
        rst = 1'b0; valid_i = 1'b1; op_i = LW; mem_addr_i = 16'h0040; alu_data_i = 16'h1234; rd_i = 4'd5;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
        #3;
        check("rst_outputs", out_bus(), 64'h0);
        check("rst_pipe_wen", 64'(pipe_wen), 64'h1);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], low, req, lv, stable, lvd, hung);
            check($sformatf("v%0d_hung", i), 64'(hung), 64'h0);
            check($sformatf("v%0d_wen_low", i), 64'(low), 64'(vecs[i].exp_low));
            check($sformatf("v%0d_req_cycles", i), 64'(req), 64'(vecs[i].exp_req));
            check($sformatf("v%0d_load_valid", i), 64'(lv), 64'(vecs[i].exp_lv));
            check($sformatf("v%0d_bus_stable", i), 64'(stable), 64'h1);
            if (vecs[i].exp_lv != 0)
                check($sformatf("v%0d_lv_data", i), 64'(lvd), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_load_data", i), 64'(load_data_o), 64'(vecs[i].exp_data));
            check($sformatf("v%0d_load_rd", i), 64'(load_rd_o), 64'(vecs[i].exp_rd));
            check($sformatf("v%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
        end

        // Reset asserted during the third BUSY cycle.
        @(posedge clk); #1;
        valid_i = 1'b1; op_i = LW; mem_addr_i = 16'h0200; alu_data_i = 16'h0; rd_i = 4'd7;
        repeat (3) @(posedge clk);
        #2;
        check("busy3_req", 64'(mem_bus.mem_req), 64'h1);
        valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_outputs", out_bus(), 64'h0);
        check("midrst_pipe_wen", 64'(pipe_wen), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (load_valid_o || mem_bus.mem_req || !pipe_wen) seen = 1'b1;
        end
        check("midrst_no_completion", 64'(seen), 64'h0);

        // Stray ack while idle must do nothing.
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (load_valid_o || mem_bus.mem_req || !pipe_wen) seen = 1'b1;
        end
        @(posedge clk); #1;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_activity", 64'(seen), 64'h0);
        check("stray_ack_data", {44'h0, load_data_o, load_rd_o}, 64'h0);

        // Random traffic against a transaction-level model.
        m_data = '0; m_rd = '0; m_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sel     = $urandom_range(0, 3);
            t.op    = (sel == 0) ? LW : (sel == 1) ? SW : 4'($urandom_range(0, 15));
            t.v     = ($urandom_range(0, 7) != 0);
            t.addr  = 16'($urandom);
            t.wdata = 16'($urandom);
            t.rd    = 4'($urandom);
            t.ack_at = $urandom_range(0, 18);
            t.rdata = 16'($urandom);
            is_mem = t.v && (t.op == LW || t.op == SW);
            is_ld  = is_mem && (t.op == LW);
            acked  = (t.ack_at >= 1) && (t.ack_at <= TMO);
            busy   = !is_mem ? 0 : (acked ? t.ack_at : TMO);
            if (is_ld) begin
                m_data = acked ? t.rdata : 16'h0;
                m_rd   = t.rd;
            end
            if (is_mem && !acked) m_err = 1'b1;
            run_txn(t, low, req, lv, stable, lvd, hung);
            check($sformatf("r%0d_hung", i), 64'(hung), 64'h0);
            check($sformatf("r%0d_wen_low", i), 64'(low), 64'(is_mem ? busy + 1 : 0));
            check($sformatf("r%0d_req_cycles", i), 64'(req), 64'(busy));
            check($sformatf("r%0d_load_valid", i), 64'(lv), 64'(is_ld ? 1 : 0));
            check($sformatf("r%0d_bus_stable", i), 64'(stable), 64'h1);
            check($sformatf("r%0d_result", i), {44'h0, load_data_o, load_rd_o}, {44'h0, m_data, m_rd});
            check($sformatf("r%0d_err", i), 64'(err_o), 64'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
